rom_bus_responder: RTL and testbench

//  ROM-side responder for the 4004 multiplexed 4-bit bus; the counterpart of the CPU fetch stage.

---
 rtl/rom4004_pkg.sv | 46 ++++
 rtl/rom_bus_responder_bus_phase_tracker.sv | 48 ++++
 rtl/rom_bus_responder.sv | 158 +++++++++++++++
 tb/tb_rom_bus_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom4004_pkg.sv
// Shared 4004 bus definitions: instruction-cycle phase encodings, ROM address payload, I/O opcodes.
// Used by the ROM-side responder and the CPU bus sequencer alike.
package rom4004_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    PH_IDLE = 4'd0,
    PH_A1   = 4'd1,
    PH_A2   = 4'd2,
    PH_A3   = 4'd3,
    PH_M1   = 4'd4,
    PH_M2   = 4'd5,
    PH_X1   = 4'd6,
    PH_X2   = 4'd7,
    PH_X3   = 4'd8
  } phase_e;

  // ROM byte address as assembled from the bus: low nibble in A1, high nibble in A2
  typedef struct packed {
    logic [NIB_W-1:0] hi;
    logic [NIB_W-1:0] lo;
  } rom_addr_t;

  localparam logic [NIB_W-1:0] OPR_IO  = 4'hE;
  localparam logic [NIB_W-1:0] OPA_WRR = 4'h2;
  localparam logic [NIB_W-1:0] OPA_RDR = 4'hA;

  // Free-running successor within an instruction cycle; X3 and IDLE depend on SYNC
  function automatic phase_e phase_after(input phase_e ph);
    phase_e nx;
    case (ph)
      PH_A1:   nx = PH_A2;
      PH_A2:   nx = PH_A3;
      PH_A3:   nx = PH_M1;
      PH_M1:   nx = PH_M2;
      PH_M2:   nx = PH_X1;
      PH_X1:   nx = PH_X2;
      PH_X2:   nx = PH_X3;
      default: nx = PH_IDLE;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/rom_bus_responder_bus_phase_tracker.sv
// bus_phase_tracker: follows SYNC through the 8-phase 4004 instruction cycle and flags lost sync.
// Shared between the ROM-side and RAM-side responders.
module bus_phase_tracker
  import rom4004_pkg::*;
(
  input  logic   clk_i,
  input  logic   res_i,
  input  logic   sync_i,
  output phase_e phase_o,
  output logic   sync_err_o
);

  phase_e phase_q, phase_d;
  logic   sync_err_q, sync_err_d;

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      phase_q    <= PH_IDLE;
      sync_err_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      sync_err_q <= sync_err_d;
    end
  end

  // SYNC always restarts at A1, wherever we believe we are
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE: phase_d = sync_i ? PH_A1 : PH_IDLE;
      PH_X3:   phase_d = sync_i ? PH_A1 : PH_IDLE;
      default: phase_d = sync_i ? PH_A1 : phase_after(phase_q);
    endcase
  end

  always_comb begin
    sync_err_d = 1'b0;
    case (phase_q)
      PH_IDLE: sync_err_d = 1'b0;
      PH_X3:   sync_err_d = !sync_i;
      default: sync_err_d = sync_i;
    endcase
  end

  assign phase_o    = phase_q;
  assign sync_err_o = sync_err_q;

endmodule

// File: rtl/rom_bus_responder.sv
// ROM-side responder for the 4004 multiplexed bus: latches the PC, reads the ROM, returns OPR/OPA.
// Optional feature macro ROM_IO_EN adds the 4-bit I/O port (SRC select, WRR write, RDR read).
module rom_bus_responder
  import rom4004_pkg::*;
#(
  parameter logic [3:0]  CHIP_ID = 4'h0,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              res_i,
  input  logic              sync_i,
  input  logic              cm_rom_i,
  input  logic [NIB_W-1:0]  d_in_i,
  output logic [NIB_W-1:0]  d_out_c_o,
  output logic              d_oe_c_o,
  output logic              rom_en_c_o,
  output logic [BYTE_W-1:0] rom_addr_o,
  input  logic [BYTE_W-1:0] rom_rdata_i,
  output logic              sync_err_o
`ifdef ROM_IO_EN
  ,
  output logic [NIB_W-1:0]  io_port_o,
  input  logic [NIB_W-1:0]  io_in_i
`endif
);

  phase_e            phase;
  rom_addr_t         addr_q, addr_d;
  logic              sel_q, sel_d;
  logic [BYTE_W-1:0] opbuf_q, opbuf_d;
  logic              chip_hit;
  logic              io_rd_en;
  logic [NIB_W-1:0]  io_rd_nib;

  bus_phase_tracker u_phase (
    .clk_i      (clk_i),
    .res_i      (res_i),
    .sync_i     (sync_i),
    .phase_o    (phase),
    .sync_err_o (sync_err_o)
  );

  assign chip_hit = (d_in_i == CHIP_ID);

  // Address latches, chip select and opcode buffer; the PC high nibble picks the ROM chip
  always_comb begin
    addr_d  = addr_q;
    sel_d   = sel_q;
    opbuf_d = opbuf_q;
    case (phase)
      PH_A1:   addr_d.lo = d_in_i;
      PH_A2:   addr_d.hi = d_in_i;
      PH_A3:   sel_d     = chip_hit;
      PH_M1:   if (sel_q) opbuf_d = rom_rdata_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      addr_q  <= '0;
      sel_q   <= 1'b0;
      opbuf_q <= '0;
    end else begin
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      opbuf_q <= opbuf_d;
    end
  end

  // ROM read is launched in A3 so the byte is back for M1
  assign rom_en_c_o = (phase == PH_A3) && chip_hit;
  assign rom_addr_o = addr_q;

`ifdef ROM_IO_EN
  logic             io_sel_q, io_sel_d;
  logic             io_cyc_q, io_cyc_d;
  logic [NIB_W-1:0] opr_s_q, opr_s_d;
  logic [NIB_W-1:0] opa_s_q, opa_s_d;
  logic [NIB_W-1:0] io_port_q, io_port_d;
  logic             io_match, wrr_hit;

  assign io_match  = io_cyc_q && io_sel_q && (opr_s_q == OPR_IO);
  assign wrr_hit   = io_match && (opa_s_q == OPA_WRR);
  assign io_rd_en  = io_match && (opa_s_q == OPA_RDR);
  assign io_rd_nib = io_in_i;

  // Snoop the opcode off the bus; SRC in X2 (CM_ROM high) selects which chip owns the port
  always_comb begin
    io_sel_d  = io_sel_q;
    io_cyc_d  = io_cyc_q;
    opr_s_d   = opr_s_q;
    opa_s_d   = opa_s_q;
    io_port_d = io_port_q;
    case (phase)
      PH_M1: opr_s_d = d_in_i;
      PH_M2: begin
        opa_s_d  = d_in_i;
        io_cyc_d = cm_rom_i;
      end
      PH_X2: begin
        if (cm_rom_i) io_sel_d = chip_hit;
        if (wrr_hit)  io_port_d = d_in_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      io_sel_q  <= 1'b0;
      io_cyc_q  <= 1'b0;
      opr_s_q   <= '0;
      opa_s_q   <= '0;
      io_port_q <= '0;
    end else begin
      io_sel_q  <= io_sel_d;
      io_cyc_q  <= io_cyc_d;
      opr_s_q   <= opr_s_d;
      opa_s_q   <= opa_s_d;
      io_port_q <= io_port_d;
    end
  end

  assign io_port_o = io_port_q;

  logic unused_ok;
  assign unused_ok = ^{opbuf_q[BYTE_W-1:NIB_W], (MEM_LAT != 32'd1)};
`else
  assign io_rd_en  = 1'b0;
  assign io_rd_nib = '0;

  logic unused_ok;
  assign unused_ok = ^{opbuf_q[BYTE_W-1:NIB_W], cm_rom_i, (MEM_LAT != 32'd1)};
`endif

  // Bus drive: OPR straight from the ROM in M1, OPA from the buffer in M2, RDR data in X2
  always_comb begin
    d_out_c_o = '0;
    d_oe_c_o  = 1'b0;
    case (phase)
      PH_M1: if (sel_q) begin
        d_out_c_o = rom_rdata_i[BYTE_W-1:NIB_W];
        d_oe_c_o  = 1'b1;
      end
      PH_M2: if (sel_q) begin
        d_out_c_o = opbuf_q[NIB_W-1:0];
        d_oe_c_o  = 1'b1;
      end
      PH_X2: if (io_rd_en) begin
        d_out_c_o = io_rd_nib;
        d_oe_c_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rom_bus_responder.sv
// Bench for rom_bus_responder (CHIP_ID=2): synchronous ROM model, bus mux, and an expected-bus scoreboard.
module tb_rom_bus_responder;
  import rom4004_pkg::*;

  localparam logic [3:0] CHIP = 4'h2;

  typedef struct packed {
    logic       oe;
    logic [3:0] d;
    logic       en;
  } exp_t;

  logic       clk = 1'b0;
  logic       res, sync, cm;
  logic [3:0] cpu_d, d_in, d_out;
  logic       d_oe, rom_en, sync_err;
  logic [7:0] rom_addr, rom_rdata;
  logic [7:0] rom_mem [256];
`ifdef ROM_IO_EN
  logic [3:0] io_port, io_in;
`endif

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  assign d_in = d_oe ? d_out : cpu_d;

  always @(posedge clk) if (rom_en) rom_rdata <= rom_mem[rom_addr];

  rom_bus_responder #(.CHIP_ID(CHIP), .MEM_LAT(1)) dut (
    .clk_i       (clk),
    .res_i       (res),
    .sync_i      (sync),
    .cm_rom_i    (cm),
    .d_in_i      (d_in),
    .d_out_c_o   (d_out),
    .d_oe_c_o    (d_oe),
    .rom_en_c_o  (rom_en),
    .rom_addr_o  (rom_addr),
    .rom_rdata_i (rom_rdata),
    .sync_err_o  (sync_err)
`ifdef ROM_IO_EN
    ,
    .io_port_o   (io_port),
    .io_in_i     (io_in)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_slot(input logic s, input logic c, input logic [3:0] d);
    sync  = s;
    cm    = c;
    cpu_d = d;
    #2;
  endtask

  function automatic logic [3:0] addr_nib(input logic [11:0] pc, input int p);
    case (p)
      0:       return pc[3:0];
      1:       return pc[7:4];
      2:       return pc[11:8];
      default: return 4'h0;
    endcase
  endfunction

  // Expected bus behaviour for one A1..X3 instruction cycle
  task automatic push_cycle(input logic [11:0] pc, input logic x2_oe, input logic [3:0] x2_d);
    logic       hit;
    logic [7:0] b;
    hit = (pc[11:8] == CHIP);
    b   = rom_mem[pc[7:0]];
    for (int p = 0; p < 8; p++) begin
      exp_t e;
      e = '0;
      if (p == 2) e.en = hit;
      if (p == 3 && hit) begin e.oe = 1'b1; e.d = b[7:4]; end
      if (p == 4 && hit) begin e.oe = 1'b1; e.d = b[3:0]; end
      if (p == 6) begin e.oe = x2_oe; e.d = x2_d; end
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    drive_slot(1'b0, 1'b0, 4'h0);
    tick();
    drive_slot(1'b0, 1'b0, 4'h0);
    tick();
    drive_slot(1'b0, 1'b0, 4'h0);
    n_chk++;
    if (dut.u_phase.phase_o !== PH_IDLE || d_oe !== 1'b0 || d_out !== 4'h0 || rom_en !== 1'b0 ||
        rom_addr !== 8'h00 || sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: phase=%0d oe=%b d=%h en=%b addr=%h err=%b, required all zero/IDLE",
               dut.u_phase.phase_o, d_oe, d_out, rom_en, rom_addr, sync_err);
    end
`ifdef ROM_IO_EN
    n_chk++;
    if (io_port !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_io_port: got %h, required 0", io_port);
    end
`endif
    res = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      drive_slot(1'b0, 1'b0, CHIP);
      n_chk++;
      if (dut.u_phase.phase_o !== PH_IDLE || sync_err !== 1'b0 || d_oe !== 1'b0 || rom_en !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: phase=%0d err=%b oe=%b en=%b, required IDLE 0 0 0",
                 i, dut.u_phase.phase_o, sync_err, d_oe, rom_en);
      end
    end
    tick();
  endtask

  task automatic test_fetch_hit();
    exp_t e;
    drive_slot(1'b1, 1'b0, 4'h0);
    tick();
    push_cycle(12'h2A5, 1'b0, 4'h0);
    for (int p = 0; p < 8; p++) begin
      drive_slot(p == 7, 1'b0, addr_nib(12'h2A5, p));
      e = exp_q.pop_front();
      n_chk++;
      if (d_oe !== e.oe || (e.oe && d_out !== e.d) || rom_en !== e.en) begin
        n_fail++;
        $display("FAIL fetch_hit phase %0d: oe=%b d=%h en=%b, required oe=%b d=%h en=%b",
                 p, d_oe, d_out, rom_en, e.oe, e.d, e.en);
      end
      if (p == 2) begin
        n_chk++;
        if (rom_addr !== 8'hA5) begin
          n_fail++;
          $display("FAIL fetch_hit rom_addr: got %h, required a5", rom_addr);
        end
      end
      tick();
    end
  endtask

  // Starts in A1 (previous X3 carried SYNC); mixes misses, hits and page-edge addresses
  task automatic test_back_to_back();
    exp_t        e;
    logic [11:0] pcs [6] = '{12'h3A5, 12'h2A5, 12'h2FF, 12'h200, 12'hF00, 12'h217};
    for (int i = 0; i < 6; i++) begin
      push_cycle(pcs[i], 1'b0, 4'h0);
      for (int p = 0; p < 8; p++) begin
        drive_slot((p == 7) && (i < 5), 1'b0, addr_nib(pcs[i], p));
        e = exp_q.pop_front();
        n_chk++;
        if (d_oe !== e.oe || (e.oe && d_out !== e.d) || rom_en !== e.en) begin
          n_fail++;
          $display("FAIL b2b pc=%h phase %0d: oe=%b d=%h en=%b, required oe=%b d=%h en=%b",
                   pcs[i], p, d_oe, d_out, rom_en, e.oe, e.d, e.en);
        end
        if (p == 2 && pcs[i][11:8] == CHIP) begin
          n_chk++;
          if (rom_addr !== pcs[i][7:0]) begin
            n_fail++;
            $display("FAIL b2b rom_addr: got %h, required %h", rom_addr, pcs[i][7:0]);
          end
        end
        tick();
      end
    end
    drive_slot(1'b0, 1'b0, 4'h0);
    n_chk++;
    if (sync_err !== 1'b1 || dut.u_phase.phase_o !== PH_IDLE || d_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL x3_sync_loss: err=%b phase=%0d oe=%b, required 1 IDLE 0",
               sync_err, dut.u_phase.phase_o, d_oe);
    end
    tick();
    drive_slot(1'b0, 1'b0, 4'h0);
    n_chk++;
    if (sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL x3_sync_err_pulse: err=%b, required 0", sync_err);
    end
    tick();
  endtask

  task automatic test_sync_loss();
    exp_t e;
    drive_slot(1'b1, 1'b0, 4'h0);
    tick();
    push_cycle(12'h2A5, 1'b0, 4'h0);
    for (int p = 0; p < 4; p++) begin
      drive_slot(p == 3, 1'b0, addr_nib(12'h2A5, p));
      e = exp_q.pop_front();
      n_chk++;
      if (d_oe !== e.oe || (e.oe && d_out !== e.d) || rom_en !== e.en) begin
        n_fail++;
        $display("FAIL sync_m1 phase %0d: oe=%b d=%h en=%b, required oe=%b d=%h en=%b",
                 p, d_oe, d_out, rom_en, e.oe, e.d, e.en);
      end
      tick();
    end
    exp_q.delete();
    push_cycle(12'h217, 1'b0, 4'h0);
    for (int p = 0; p < 8; p++) begin
      drive_slot(1'b0, 1'b0, addr_nib(12'h217, p));
      if (p == 0) begin
        n_chk++;
        if (sync_err !== 1'b1 || dut.u_phase.phase_o !== PH_A1) begin
          n_fail++;
          $display("FAIL resync: err=%b phase=%0d, required 1 A1", sync_err, dut.u_phase.phase_o);
        end
      end
      e = exp_q.pop_front();
      n_chk++;
      if (d_oe !== e.oe || (e.oe && d_out !== e.d) || rom_en !== e.en) begin
        n_fail++;
        $display("FAIL after_resync phase %0d: oe=%b d=%h en=%b, required oe=%b d=%h en=%b",
                 p, d_oe, d_out, rom_en, e.oe, e.d, e.en);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_m1();
    exp_t e;
    drive_slot(1'b1, 1'b0, 4'h0);
    tick();
    push_cycle(12'h2A5, 1'b0, 4'h0);
    for (int p = 0; p < 4; p++) begin
      drive_slot(1'b0, 1'b0, addr_nib(12'h2A5, p));
      e = exp_q.pop_front();
      n_chk++;
      if (d_oe !== e.oe || (e.oe && d_out !== e.d) || rom_en !== e.en) begin
        n_fail++;
        $display("FAIL pre_reset phase %0d: oe=%b d=%h en=%b, required oe=%b d=%h en=%b",
                 p, d_oe, d_out, rom_en, e.oe, e.d, e.en);
      end
      if (p == 3) res = 1'b1;
      tick();
    end
    exp_q.delete();
    drive_slot(1'b0, 1'b0, 4'h0);
    n_chk++;
    if (d_oe !== 1'b0 || dut.u_phase.phase_o !== PH_IDLE || rom_addr !== 8'h00 || sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_m1: oe=%b phase=%0d addr=%h err=%b, required 0 IDLE 00 0",
               d_oe, dut.u_phase.phase_o, rom_addr, sync_err);
    end
    res = 1'b0;
    drive_slot(1'b1, 1'b0, 4'h0);
    tick();
    push_cycle(12'h2A5, 1'b0, 4'h0);
    for (int p = 0; p < 8; p++) begin
      drive_slot(1'b0, 1'b0, addr_nib(12'h2A5, p));
      e = exp_q.pop_front();
      n_chk++;
      if (d_oe !== e.oe || (e.oe && d_out !== e.d) || rom_en !== e.en) begin
        n_fail++;
        $display("FAIL restart phase %0d: oe=%b d=%h en=%b, required oe=%b d=%h en=%b",
                 p, d_oe, d_out, rom_en, e.oe, e.d, e.en);
      end
      tick();
    end
  endtask

`ifdef ROM_IO_EN
  // SRC to this chip, WRR, RDR, then SRC elsewhere so WRR/RDR must be ignored
  task automatic test_rom_io();
    exp_t        e;
    logic [11:0] pcs    [6] = '{12'h220, 12'h230, 12'h231, 12'h220, 12'h230, 12'h231};
    logic        cm_m2  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        cm_x2  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  x2_d   [6] = '{4'h2, 4'h9, 4'h0, 4'h3, 4'h5, 4'h0};
    logic        x2_oe  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  port_e [6] = '{4'h0, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9};
    logic [3:0]  nib;
    logic        c;
    io_in = 4'h6;
    drive_slot(1'b1, 1'b0, 4'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      push_cycle(pcs[i], x2_oe[i], 4'h6);
      for (int p = 0; p < 8; p++) begin
        nib = (p == 6) ? x2_d[i] : addr_nib(pcs[i], p);
        c   = (p == 4) ? cm_m2[i] : ((p == 6) ? cm_x2[i] : 1'b0);
        drive_slot((p == 7) && (i < 5), c, nib);
        e = exp_q.pop_front();
        n_chk++;
        if (d_oe !== e.oe || (e.oe && d_out !== e.d) || rom_en !== e.en) begin
          n_fail++;
          $display("FAIL io cyc%0d phase %0d: oe=%b d=%h en=%b, required oe=%b d=%h en=%b",
                   i, p, d_oe, d_out, rom_en, e.oe, e.d, e.en);
        end
        if (p == 7) begin
          n_chk++;
          if (io_port !== port_e[i]) begin
            n_fail++;
            $display("FAIL io_port cyc%0d: got %h, required %h", i, io_port, port_e[i]);
          end
        end
        tick();
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    res   = 1'b1;
    sync  = 1'b0;
    cm    = 1'b0;
    cpu_d = 4'h0;
`ifdef ROM_IO_EN
    io_in = 4'h0;
`endif
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i * 37 + 11) ^ 8'h5A;
    rom_mem[8'hA5] = 8'h3C;
    rom_mem[8'h17] = 8'h9B;
    rom_mem[8'hFF] = 8'hD1;
    rom_mem[8'h00] = 8'h4E;
    rom_mem[8'h20] = 8'h25;
    rom_mem[8'h30] = 8'hE2;
    rom_mem[8'h31] = 8'hEA;

    test_reset();
    test_fetch_hit();
    test_back_to_back();
    test_sync_loss();
    test_reset_mid_m1();
`ifdef ROM_IO_EN
    test_rom_io();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
